// File: rtl/mc_pkg.sv
// mc_pkg: state encoding and decoder constants shared by the multicycle sequencer.
package mc_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;
   localparam logic [2:0] JT_NONE = 3'd0;
   localparam logic [2:0] JT_BEQ  = 3'd1;
   localparam logic [2:0] JT_JR   = 3'd2;
   localparam logic [2:0] JT_JAL  = 3'd3;
   localparam logic [2:0] JT_J    = 3'd4;
   localparam logic [3:0] OP_NOT_DEFINED = 4'b1111;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational sequential/branch/jump target selection for the PC.
module pc_next_calc import mc_pkg::*; #(
   parameter int DWIDTH = 32
) (
   input  logic [DWIDTH-1:0] pc,
   input  logic [2:0]        jump_type,
   input  logic              alu_zero,
   input  logic [DWIDTH-1:0] imm,
   input  logic [25:0]       jump_addr,
   input  logic [DWIDTH-1:0] rs1_data,
   output logic [DWIDTH-1:0] pc4,
   output logic [DWIDTH-1:0] next_pc
);
   always_comb begin
      pc4 = pc + DWIDTH'(4);
      next_pc = (jump_type == JT_BEQ && alu_zero) ? pc4 + (imm << 2) :
                (jump_type == JT_JR) ? rs1_data :
                (jump_type == JT_J || jump_type == JT_JAL) ? {pc4[DWIDTH-1:28], jump_addr, 2'b00} :
                pc4;
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, IR, memory handshakes
// and one-cycle writeback strobes.
module multicycle_ctrl import mc_pkg::*; #(
   parameter int                 DWIDTH      = 32,
   parameter logic [DWIDTH-1:0]  RESET_PC    = '0,
   parameter int                 MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   output logic              imem_req,
   output logic [DWIDTH-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DWIDTH-1:0] imem_rdata,
   output logic [DWIDTH-1:0] ir,
   input  logic [3:0]        op,
   input  logic [2:0]        jump_type,
   input  logic [25:0]       jump_addr,
   input  logic [DWIDTH-1:0] imm,
   input  logic              is_load,
   input  logic              is_store,
   input  logic              reg_write,
   input  logic              alu_zero,
   input  logic [DWIDTH-1:0] rs1_data,
   output logic              dmem_req,
   output logic              dmem_we,
   input  logic              dmem_ack,
   output logic              rf_we,
   output logic              link_we,
   output logic [DWIDTH-1:0] link_pc,
   output logic [DWIDTH-1:0] pc,
   output logic              busy,
   output logic              trap,
   output logic [31:0]       retired
);
   localparam logic [3:0] TO_LAST = 4'(MEM_TIMEOUT - 1);
   state_t            state;
   logic [3:0]        cnt;
   logic [DWIDTH-1:0] pc4;
   logic [DWIDTH-1:0] next_pc;
   logic              wb_rf;
   logic              wb_link;
   pc_next_calc #(.DWIDTH(DWIDTH)) u_next (
      .pc        (pc),
      .jump_type (jump_type),
      .alu_zero  (alu_zero),
      .imm       (imm),
      .jump_addr (jump_addr),
      .rs1_data  (rs1_data),
      .pc4       (pc4),
      .next_pc   (next_pc)
   );
   assign imem_addr = pc;
   assign link_pc   = pc4;
   assign trap      = (state == S_TRAP);
   assign busy      = !(state == S_IDLE || state == S_TRAP);
   assign wb_rf     = reg_write | is_load;
   assign wb_link   = (jump_type == JT_JAL);
   // Strobes are registered, so they are raised on the edge that enters the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         ir       <= '0;
         retired  <= '0;
         cnt      <= '0;
         imem_req <= 1'b0;
         dmem_req <= 1'b0;
         dmem_we  <= 1'b0;
         rf_we    <= 1'b0;
         link_we  <= 1'b0;
      end else begin
         rf_we   <= 1'b0;
         link_we <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
               cnt      <= '0;
            end
            S_FETCH: if (imem_ack) begin
               ir       <= imem_rdata;
               imem_req <= 1'b0;
               state    <= S_DECODE;
            end else if (cnt == TO_LAST) begin
               imem_req <= 1'b0;
               state    <= S_TRAP;
            end else begin
               cnt <= cnt + 4'd1;
            end
            S_DECODE: state <= (op == OP_NOT_DEFINED && jump_type == JT_NONE) ? S_TRAP : S_EXEC;
            S_EXEC: if (is_load | is_store) begin
               state    <= S_MEM;
               dmem_req <= 1'b1;
               dmem_we  <= is_store;
               cnt      <= '0;
            end else begin
               state   <= S_WB;
               rf_we   <= wb_rf;
               link_we <= wb_link;
            end
            S_MEM: if (dmem_ack) begin
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
               state    <= S_WB;
               rf_we    <= wb_rf;
               link_we  <= wb_link;
            end else if (cnt == TO_LAST) begin
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
               state    <= S_TRAP;
            end else begin
               cnt <= cnt + 4'd1;
            end
            S_WB: begin
               pc      <= next_pc;
               retired <= retired + 32'd1;
               if (stop) begin
                  state <= S_IDLE;
               end else begin
                  state    <= S_FETCH;
                  imem_req <= 1'b1;
                  cnt      <= '0;
               end
            end
            default: state <= S_TRAP;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for the multicycle sequencer with
// hand-computed expectations; decoder fields are driven directly by the bench.
module tb_multicycle_ctrl;
   import mc_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, stop = 1'b1;
   logic        imem_req, imem_ack = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0, ir;
   logic [3:0]  op = 4'h2;
   logic [2:0]  jump_type = JT_NONE;
   logic [25:0] jump_addr = '0;
   logic [31:0] imm = '0, rs1_data = '0;
   logic        is_load = 1'b0, is_store = 1'b0, reg_write = 1'b0, alu_zero = 1'b0;
   logic        dmem_req, dmem_we, dmem_ack = 1'b0;
   logic        rf_we, link_we, busy, trap;
   logic [31:0] link_pc, pc, retired;
   int          n_cmp = 0, n_err = 0;

   multicycle_ctrl #(.DWIDTH(32), .RESET_PC(32'h0), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir(ir), .op(op), .jump_type(jump_type), .jump_addr(jump_addr), .imm(imm),
      .is_load(is_load), .is_store(is_store), .reg_write(reg_write), .alu_zero(alu_zero),
      .rs1_data(rs1_data), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .link_we(link_we), .link_pc(link_pc), .pc(pc),
      .busy(busy), .trap(trap), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // From IDLE with a same-cycle fetch ack; returns with the core sitting in WB.
   task automatic run_to_wb(input logic [31:0] instr);
      imem_rdata = instr;
      imem_ack = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      imem_ack = 1'b0;
      tick;
      tick;
   endtask

   initial begin
      tick;
      tick;
      check("rst_pc", pc, 32'h0);
      check("rst_ir", ir, 32'h0);
      check("rst_retired", retired, 32'h0);
      check("rst_trap", {31'b0, trap}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_imem_req", {31'b0, imem_req}, 32'h0);
      rst_n = 1'b1;
      tick;
      check("idle_no_req", {31'b0, imem_req}, 32'h0);

      // ADD, same-cycle ack
      reg_write = 1'b1;
      imem_rdata = 32'h012A4020;
      imem_ack = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      check("add_c1_req", {31'b0, imem_req}, 32'h1);
      check("add_c1_addr", imem_addr, 32'h0);
      check("add_c1_busy", {31'b0, busy}, 32'h1);
      tick;
      imem_ack = 1'b0;
      check("add_c2_ir", ir, 32'h012A4020);
      check("add_c2_req", {31'b0, imem_req}, 32'h0);
      check("add_c2_rf_we", {31'b0, rf_we}, 32'h0);
      tick;
      check("add_c3_rf_we", {31'b0, rf_we}, 32'h0);
      tick;
      check("add_c4_rf_we", {31'b0, rf_we}, 32'h1);
      check("add_c4_pc", pc, 32'h0);
      tick;
      check("add_rf_we_drop", {31'b0, rf_we}, 32'h0);
      check("add_pc", pc, 32'h4);
      check("add_retired", retired, 32'h1);
      check("add_idle", {31'b0, busy}, 32'h0);

      // LW at pc=4, dmem_ack after 3 wait cycles; start+stop together in IDLE
      is_load = 1'b1;
      imem_rdata = 32'h8D090004;
      imem_ack = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      check("lw_fetch_req", {31'b0, imem_req}, 32'h1);
      tick;
      imem_ack = 1'b0;
      tick;
      check("lw_exec_dreq", {31'b0, dmem_req}, 32'h0);
      tick;
      check("lw_m1_dreq", {31'b0, dmem_req}, 32'h1);
      check("lw_m1_dwe", {31'b0, dmem_we}, 32'h0);
      tick;
      check("lw_m2_dreq", {31'b0, dmem_req}, 32'h1);
      tick;
      check("lw_m3_dreq", {31'b0, dmem_req}, 32'h1);
      check("lw_m3_rf_we", {31'b0, rf_we}, 32'h0);
      tick;
      dmem_ack = 1'b1;
      check("lw_m4_dreq", {31'b0, dmem_req}, 32'h1);
      tick;
      dmem_ack = 1'b0;
      check("lw_wb_dreq", {31'b0, dmem_req}, 32'h0);
      check("lw_wb_rf_we", {31'b0, rf_we}, 32'h1);
      tick;
      is_load = 1'b0;
      reg_write = 1'b0;
      check("lw_pc", pc, 32'h8);
      check("lw_retired", retired, 32'h2);

      // BEQ taken at pc=8, imm=3 -> 24
      op = 4'h6;
      jump_type = JT_BEQ;
      imm = 32'd3;
      alu_zero = 1'b1;
      run_to_wb(32'h11090003);
      check("beq_t_rf_we", {31'b0, rf_we}, 32'h0);
      tick;
      check("beq_t_pc", pc, 32'd24);

      // JR back to 8, then BEQ not taken -> 12
      op = 4'h0;
      jump_type = JT_JR;
      rs1_data = 32'h8;
      run_to_wb(32'h01000008);
      tick;
      check("jr8_pc", pc, 32'h8);
      op = 4'h6;
      jump_type = JT_BEQ;
      alu_zero = 1'b0;
      run_to_wb(32'h11090003);
      tick;
      check("beq_nt_pc", pc, 32'd12);

      // JAL at 12 -> 0x100, then JAL at 0x100
      op = 4'h0;
      jump_type = JT_JAL;
      jump_addr = 26'h40;
      run_to_wb(32'h0C000040);
      check("jal1_link_we", {31'b0, link_we}, 32'h1);
      check("jal1_link_pc", link_pc, 32'h10);
      tick;
      check("jal1_pc", pc, 32'h100);
      check("jal1_link_drop", {31'b0, link_we}, 32'h0);
      run_to_wb(32'h0C000040);
      check("jal2_link_we", {31'b0, link_we}, 32'h1);
      check("jal2_link_pc", link_pc, 32'h104);
      tick;
      check("jal2_pc", pc, 32'h100);

      // JR to 0x104
      jump_type = JT_JR;
      rs1_data = 32'h104;
      run_to_wb(32'h03E00008);
      check("jr_link_we", {31'b0, link_we}, 32'h0);
      tick;
      check("jr_pc", pc, 32'h104);
      check("jr_retired", retired, 32'd8);

      // ADD with stop=0 rolls straight into FETCH; then withhold imem_ack
      op = 4'h2;
      jump_type = JT_NONE;
      reg_write = 1'b1;
      run_to_wb(32'h012A4020);
      stop = 1'b0;
      tick;
      stop = 1'b1;
      check("chain_req", {31'b0, imem_req}, 32'h1);
      check("chain_addr", imem_addr, 32'h108);
      check("chain_retired", retired, 32'd9);
      for (int i = 0; i < 15; i++) begin
         check($sformatf("to_req_%0d", i), {31'b0, imem_req}, 32'h1);
         tick;
      end
      check("to_trap", {31'b0, trap}, 32'h1);
      check("to_busy", {31'b0, busy}, 32'h0);
      check("to_req_drop", {31'b0, imem_req}, 32'h0);
      start = 1'b1;
      imem_ack = 1'b1;
      tick;
      tick;
      start = 1'b0;
      imem_ack = 1'b0;
      check("to_trap_sticky", {31'b0, trap}, 32'h1);
      check("to_no_req", {31'b0, imem_req}, 32'h0);
      check("to_pc_frozen", pc, 32'h108);
      check("to_retired_frozen", retired, 32'd9);

      // Undefined opcode traps at DECODE
      rst_n = 1'b0;
      tick;
      check("rst2_trap", {31'b0, trap}, 32'h0);
      check("rst2_pc", pc, 32'h0);
      rst_n = 1'b1;
      reg_write = 1'b0;
      op = OP_NOT_DEFINED;
      imem_rdata = 32'hFC000000;
      imem_ack = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      imem_ack = 1'b0;
      tick;
      check("undef_trap", {31'b0, trap}, 32'h1);
      check("undef_busy", {31'b0, busy}, 32'h0);
      tick;
      check("undef_no_req", {31'b0, imem_req | dmem_req | rf_we}, 32'h0);
      check("undef_retired", retired, 32'h0);

      // Async reset in the middle of a store's MEM phase
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      op = 4'h2;
      reg_write = 1'b1;
      run_to_wb(32'h012A4020);
      tick;
      check("pre_sw_pc", pc, 32'h4);
      reg_write = 1'b0;
      is_store = 1'b1;
      imem_rdata = 32'hAD090004;
      imem_ack = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      imem_ack = 1'b0;
      tick;
      tick;
      check("sw_dreq", {31'b0, dmem_req}, 32'h1);
      check("sw_dwe", {31'b0, dmem_we}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_dreq", {31'b0, dmem_req}, 32'h0);
      check("async_dwe", {31'b0, dmem_we}, 32'h0);
      check("async_pc", pc, 32'h0);
      check("async_retired", retired, 32'h0);
      check("async_busy", {31'b0, busy}, 32'h0);
      is_store = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      tick;
      check("post_rst_idle", {31'b0, busy}, 32'h0);
      check("post_rst_no_req", {31'b0, imem_req}, 32'h0);
      start = 1'b1;
      tick;
      start = 1'b0;
      check("post_rst_start", {31'b0, imem_req}, 32'h1);
      check("post_rst_addr", imem_addr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
